mult_seq: RTL and testbench

MULT_SEQ -- requirements
Module: mult_seq

---
 rtl/mult_seq.sv | 104 ++++++++++
 tb/tb_mult_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// mult_seq: sequential multiplier that retires one 2-bit multiplier digit per cycle.
// Signed operands are reduced to magnitudes up front and the sign is reapplied when the result is stored.
module mult_seq #(
  parameter int WIDTH = 8,
  localparam int DIGITS = WIDTH / 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               abort,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);
  localparam int PW = 2 * WIDTH;
  localparam int KW = $clog2(DIGITS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] a_q, a_d, acc_q, acc_d, out_q, out_d, part, sum;
  logic [WIDTH-1:0] b_q, b_d, a_mag, b_mag;
  logic [KW-1:0] k_q, k_d;
  logic neg_q, neg_d, sm_q, sm_d, ov_q, ov_d, last;
  // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude
  assign a_mag = (signed_mode && A[WIDTH-1]) ? -A : A;
  assign b_mag = (signed_mode && B[WIDTH-1]) ? -B : B;
  // a_q is pre-shifted by 2k and b_q holds the remaining digits in its low bits
  assign part = (b_q[0] ? a_q : '0) + (b_q[1] ? a_q << 1 : '0);
  assign sum = acc_q + part;
  assign last = k_q == KW'(DIGITS - 1);
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out = out_q;
  assign out_valid = ov_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    k_d = k_q;
    neg_d = neg_q;
    sm_d = sm_q;
    out_d = out_q;
    ov_d = ov_q;
    case (state_q)
      IDLE: if (in_valid && !abort) begin
        state_d = RUN;
        a_d = {{WIDTH{1'b0}}, a_mag};
        b_d = b_mag;
        neg_d = signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
        sm_d = signed_mode;
        acc_d = '0;
        k_d = '0;
      end
      RUN: if (abort) begin
        state_d = IDLE;
        acc_d = '0;
      end else begin
        acc_d = sum;
        a_d = a_q << 2;
        b_d = b_q >> 2;
        k_d = k_q + 1'b1;
        if (last) begin
          state_d = DONE;
          ov_d = 1'b1;
          out_d = (sm_q && neg_q) ? -sum : sum;
        end
      end
      DONE: if (abort || out_ready) begin
        state_d = IDLE;
        ov_d = 1'b0;
        acc_d = abort ? '0 : acc_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      k_q <= '0;
      neg_q <= 1'b0;
      sm_q <= 1'b0;
      out_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      k_q <= k_d;
      neg_q <= neg_d;
      sm_q <= sm_d;
      out_q <= out_d;
      ov_q <= ov_d;
    end
  end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed vectors for mult_seq, with a queue of expected products checked by a monitor.
module tb_mult_seq;
  logic clk = 0, rst_n = 0;
  logic [7:0] A = 0, B = 0;
  logic signed_mode = 0, in_valid = 0, abort = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [15:0] out;
  typedef struct {logic [15:0] v; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  int pass = 0, total = 0, cyc = 0;
  bit prev_ov = 0;
  mult_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .abort(abort), .out(out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask
  always @(posedge clk) begin
    cyc++;
    #1;
    if (out_valid && !prev_ov) begin
      if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
      else begin
        e = q.pop_front();
        chk("product", out, e.v);
        chk("latency", cyc - e.c, 4);
      end
    end
    prev_ov = out_valid;
  end
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input bit sm, input logic [15:0] exp, input bit push);
    @(negedge clk);
    A = a;
    B = b;
    signed_mode = sm;
    in_valid = 1;
    if (push) q.push_back('{v: exp, c: cyc + 1});
    @(negedge clk);
    in_valid = 0;
    chk("in_ready_in_run", in_ready, 0);
  endtask
  task automatic wait_done(input bit scramble);
    int n = 0;
    while (!out_valid && n < 20) begin
      chk("busy_in_run", busy, 1);
      if (scramble) begin
        A = 8'($urandom);
        B = 8'($urandom);
        signed_mode = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("done_timeout", out_valid, 1);
  endtask
  task automatic drain();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("out_valid_cleared", out_valid, 0);
    chk("busy_after_drain", busy, 0);
    chk("in_ready_after_drain", in_ready, 1);
  endtask
  task automatic op(input logic [7:0] a, input logic [7:0] b, input bit sm, input logic [15:0] exp);
    issue(a, b, sm, exp, 1);
    wait_done(0);
    drain();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #2;
    chk("reset_out", out, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    op(8'd15, 8'd13, 0, 16'h00C3);
    op(8'd255, 8'd255, 0, 16'hFE01);
    op(8'h80, 8'h80, 1, 16'h4000);
    op(8'hFD, 8'd5, 1, 16'hFFF1);
    op(8'd127, 8'hFF, 1, 16'hFF81);
    op(8'd0, 8'd200, 0, 16'h0000);
    op(8'h80, 8'd127, 1, 16'hC080);
    op(8'hFF, 8'hFF, 1, 16'h0001);
    op(8'h80, 8'hFF, 0, 16'h7F80);
    issue(8'd9, 8'd11, 0, 16'h0063, 1);
    wait_done(0);
    repeat (10) begin
      chk("bp_out", out, 16'h0063);
      chk("bp_out_valid", out_valid, 1);
      in_valid = ~in_valid;
      A = 8'($urandom);
      B = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1;
    drain();
    in_valid = 0;
    issue(8'd200, 8'd3, 0, 16'h0258, 1);
    wait_done(1);
    drain();
    issue(8'd10, 8'd10, 0, 16'h0000, 0);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    repeat (6) @(negedge clk);
    in_valid = 1;
    abort = 1;
    @(negedge clk);
    in_valid = 0;
    abort = 0;
    chk("abort_blocks_accept", busy, 0);
    op(8'd6, 8'd7, 0, 16'h002A);
    issue(8'd50, 8'd50, 0, 16'h0000, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    op(8'd15, 8'd13, 0, 16'h00C3);
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
